matrix_feeder: RTL and testbench
================================

# matrix_feeder

Upstream loader for `matrix_mult`. It accepts the A and B operand elements from a host over a valid/ready handshake and buffers both matrices. When both are complete, it issues the `start` pulse, waits a fixed idle gap, and then streams all elements one per clock into `matrix_mult`'s `data_in`. It holds off the next job until `matrix_mult` reports `done`.

## Interface
- `DW`, 8: element width in bits.
- `m`, 8: matrix rows.
- `n`, 8: matrix columns. Each operand is m*n elements; the job total is T = 2*m*n.
- `GAP`, 1: idle cycles between the `mm_start` pulse and the first streamed element. 0 is legal.
- `TIMEOUT`, 4096: maximum WAIT_DONE cycles. Used only when `MATRIX_FEEDER_TIMEOUT_EN` is defined.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high. All state clears immediately.
- `in_data`, input, DW: host element. Order is row-major, A first, then B.
- `in_valid`, input, 1: host element valid.
- `in_ready`, output, 1: feeder can accept an element.
- `mm_start`, output, 1: one-cycle start pulse to `matrix_mult.start`.
- `mm_data`, output, DW: element stream to `matrix_mult.data_in`. Registered.
- `mm_done`, input, 1: `matrix_mult.done`.
- `busy`, output, 1: high in every state except LOAD.
- `err`, output, 1: sticky timeout flag.

## Operation
- Buffer: T x DW register array. Write index `wr_cnt` and read index `rd_cnt` are each `$clog2(T+1)` bits wide.
- LOAD state:
  - `in_ready` = (`wr_cnt` < T).
  - On `in_valid && in_ready`, `buf[wr_cnt] <= in_data` and `wr_cnt` increments.
  - The edge that accepts element T-1 moves the FSM to START.
- START state: `mm_start` = 1 for exactly one cycle.
  - Go to GAP with `gap_cnt` = 0 if GAP > 0.
  - Go straight to STREAM if GAP == 0.
- GAP state: `mm_data` = 0. After GAP cycles, go to STREAM with `rd_cnt` = 0.
- STREAM state: `mm_data` = `buf[rd_cnt]` for exactly one cycle per element, k = 0..T-1, with no bubbles.
  - After element T-1, go to WAIT_DONE.
  - `mm_data` returns to 0 in the cycle after the last element.
- WAIT_DONE state: `mm_data` = 0.
  - `mm_done` sampled high goes to LOAD with `wr_cnt` = 0 and `rd_cnt` = 0.
  - Buffer contents are not cleared.
- `mm_done` is ignored in every state other than WAIT_DONE, including a `mm_done` that arrives during the last STREAM cycle.
- `in_ready` = 0 in all states other than LOAD. Host data presented while `in_ready` = 0 is not consumed.
- Element values pass through unmodified; there is no arithmetic on data.
- Reset mid-operation, in any state, has the following effect:
  - The FSM goes to LOAD.
  - Both counters, `mm_start`, `mm_data`, `busy` and `err` go to 0.
  - A partially loaded job is discarded.

## Timing
- Reset values: `in_ready` = 1, `mm_start` = 0, `mm_data` = 0, `busy` = 0, `err` = 0.
- Let edge E accept element T-1. Then:
  - `mm_start` is high in the cycle after E (cycle 1).
  - GAP idle cycles follow (cycles 2..GAP+1).
  - Element k is on `mm_data` in cycle GAP+2+k.
  - WAIT_DONE begins in cycle GAP+2+T.
- `busy` rises in cycle 1 and falls in the cycle after `mm_done` is sampled.
- `in_ready` re-asserts in the same cycle that `busy` falls.
- Minimum job turnaround is T load cycles, plus 1 + GAP + T, plus at least 1 WAIT_DONE cycle.
- Host throughput in LOAD is 1 element per cycle while `in_valid` is held high. Valid gaps are allowed at any point.

## Configuration
- `MATRIX_FEEDER_TIMEOUT_EN` defined:
  - A WAIT_DONE cycle counter runs.
  - If `mm_done` has not been seen after TIMEOUT cycles in WAIT_DONE, `err` is set sticky and the FSM returns to LOAD with counters cleared.
  - `err` clears only on `reset`.
- `MATRIX_FEEDER_TIMEOUT_EN` not defined:
  - No counter is built.
  - `err` is tied to 0.
  - WAIT_DONE waits indefinitely.

## Test plan
- m=n=2, GAP=1. Load 1..8 back-to-back. Required response:
  - `mm_start` high for one cycle.
  - One idle cycle with `mm_data` = 0.
  - `mm_data` = 1,2,3,4,5,6,7,8 on consecutive cycles.
  - `busy` = 1 until `mm_done` is pulsed.
- Load 1..8 with random `in_valid` gaps. Required response: identical stream and ordering, and `mm_start` one cycle after the 8th accept.
- Hold `in_valid` high with a 9th value (9) after the 8th accept. Required response: `in_ready` = 0 and 9 is not consumed until `mm_done`. The next job's first buffered element is 9.
- Pulse `mm_done` during GAP and during the STREAM cycle carrying 8. Required response: both are ignored, and the FSM stays in WAIT_DONE until a later `mm_done`.
- Assert `reset` while streaming element 3. Required response: all outputs go to 0 immediately and `in_ready` = 1. A fresh load of 1..8 then streams correctly.
- With `MATRIX_FEEDER_TIMEOUT_EN` defined and TIMEOUT=16, never assert `mm_done`. Required response:
  - `err` = 1 after 16 WAIT_DONE cycles.
  - `busy` = 0 and `in_ready` = 1.
  - `err` stays 1 through the next job.

Source files
------------

// File: rtl/matrix_feeder.sv
// Operand loader for matrix_mult: buffers A then B from the host, pulses start, then streams every element.
// Optional WAIT_DONE watchdog enabled by defining MATRIX_FEEDER_TIMEOUT_EN.
module matrix_feeder #(
    parameter int DW      = 8,
    parameter int m       = 8,
    parameter int n       = 8,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mm_start,
    output logic [DW-1:0] mm_data,
    input  logic          mm_done,
    output logic          busy,
    output logic          err
);

    localparam int T  = 2 * m * n;
    localparam int CW = $clog2(T + 1);
    localparam int AW = (T > 1) ? $clog2(T) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] T_CNT    = CW'(T);
    localparam logic [CW-1:0] LAST_IDX = CW'(T - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_GAP,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t        state;
    logic [DW-1:0] elem_buf [T];
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] rd_nxt;
    logic [GW-1:0] gap_cnt;
    logic          accept;

`ifdef MATRIX_FEEDER_TIMEOUT_EN
    localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    logic [TOW-1:0] to_cnt;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

    assign in_ready = (state == S_LOAD) && (wr_cnt < T_CNT);
    assign accept   = in_valid && in_ready;
    assign rd_nxt   = rd_cnt + CW'(1);

    // Buffer holds data only; it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            elem_buf[wr_cnt[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LOAD;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            gap_cnt  <= '0;
            mm_start <= 1'b0;
            mm_data  <= '0;
            busy     <= 1'b0;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
            err      <= 1'b0;
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state    <= S_START;
                            mm_start <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    mm_start <= 1'b0;
                    if (GAP == 0) begin
                        state   <= S_STREAM;
                        rd_cnt  <= '0;
                        mm_data <= elem_buf[0];
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= S_STREAM;
                        rd_cnt  <= '0;
                        mm_data <= elem_buf[0];
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_STREAM: begin
                    // mm_done is not looked at here, even on the final element.
                    if (rd_cnt == LAST_IDX) begin
                        state   <= S_WAIT;
                        mm_data <= '0;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end else begin
                        rd_cnt  <= rd_nxt;
                        mm_data <= elem_buf[rd_nxt[AW-1:0]];
                    end
                end
                S_WAIT: begin
                    if (mm_done) begin
                        state  <= S_LOAD;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        busy   <= 1'b0;
                    end
`ifdef MATRIX_FEEDER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        err    <= 1'b1;
                        state  <= S_LOAD;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        busy   <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
`endif
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder (m=n=2, GAP=1, TIMEOUT=16): expected elements queued as the host drives them.
module tb_matrix_feeder;

    localparam int DW  = 8;
    localparam int M   = 2;
    localparam int N   = 2;
    localparam int GP  = 1;
    localparam int TO  = 16;
    localparam int T   = 2 * M * N;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mm_start;
    logic [DW-1:0] mm_data;
    logic          mm_done;
    logic          busy;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    matrix_feeder #(
        .DW(DW), .m(M), .n(N), .GAP(GP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mm_start(mm_start), .mm_data(mm_data), .mm_done(mm_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive values first..first+count-1; each is queued as expected at its accepting edge.
    task automatic load(input int first, input int count, input bit gaps, input bit hold_after);
        for (int i = 0; i < count; i++) begin
            int guard;
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'hEE;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = DW'(first + i);
            guard = 0;
            while (!in_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) check_val("ready_wait", 32'(in_ready), 1);
            exp_q.push_back(DW'(first + i));
            tick();
        end
        if (!hold_after) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
        end
    endtask

    // Called in the cycle after the last accept; ends in the first WAIT_DONE cycle.
    task automatic check_stream(input bit done_in_gap, input bit done_on_last);
        check_val("start_hi", 32'(mm_start), 1);
        check_val("busy_rise", 32'(busy), 1);
        check_val("rdy_start", 32'(in_ready), 0);
        tick();
        check_val("start_pulse", 32'(mm_start), 0);
        for (int g = 0; g < GP; g++) begin
            check_val("gap_data", 32'(mm_data), 0);
            if (done_in_gap) mm_done = 1'b1;
            tick();
            mm_done = 1'b0;
        end
        for (int k = 0; k < T; k++) begin
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 32'(mm_data), 32'hFFFF_FFFF);
            end else begin
                check_val("stream", 32'(mm_data), 32'(exp_q.pop_front()));
            end
            check_val("rdy_stream", 32'(in_ready), 0);
            if (done_on_last && k == T - 1) mm_done = 1'b1;
            tick();
            mm_done = 1'b0;
        end
        check_val("tail_zero", 32'(mm_data), 0);
        check_val("busy_wait", 32'(busy), 1);
    endtask

    task automatic finish_job();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        check_val("busy_fall", 32'(busy), 0);
        check_val("ready_back", 32'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0, expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mm_done  = 1'b0;
        #1;
        check_val("rst_ready", 32'(in_ready), 1);
        check_val("rst_start", 32'(mm_start), 0);
        check_val("rst_data", 32'(mm_data), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_err", 32'(err), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back load, then verify done is required.
        load(1, T, 1'b0, 1'b0);
        check_stream(1'b0, 1'b0);
`ifndef MATRIX_FEEDER_TIMEOUT_EN
        for (int i = 0; i < 20; i++) tick();
        check_val("wait_forever", 32'(busy), 1);
`endif
        finish_job();

        // Random valid gaps, done pulses ignored in GAP and last STREAM cycle,
        // and a 9th element held on the bus that must wait for the next job.
        load(1, T, 1'b1, 1'b1);
        in_data = 8'd9;
        check_stream(1'b1, 1'b1);
        check_val("ignored_done", 32'(busy), 1);
        tick();
        check_val("still_wait", 32'(busy), 1);
        check_val("held_rdy", 32'(in_ready), 0);
        finish_job();
        load(9, T, 1'b0, 1'b0);
        check_stream(1'b0, 1'b0);
        finish_job();

        // Reset while element 3 is on mm_data.
        load(1, T, 1'b0, 1'b0);
        begin
            int guard;
            guard = 0;
            while (mm_data != 8'd3 && guard < 20) begin
                tick();
                guard++;
            end
            check_val("reach_elem3", 32'(mm_data), 3);
        end
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_data", 32'(mm_data), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_start", 32'(mm_start), 0);
        check_val("mid_rst_ready", 32'(in_ready), 1);
        check_val("mid_rst_err", 32'(err), 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        load(1, T, 1'b0, 1'b0);
        check_stream(1'b0, 1'b0);

`ifdef MATRIX_FEEDER_TIMEOUT_EN
        // Already in WAIT cycle 1; err lands after the 16th WAIT cycle.
        for (int i = 0; i < TO - 1; i++) tick();
        check_val("to_pre_err", 32'(err), 0);
        check_val("to_pre_busy", 32'(busy), 1);
        tick();
        check_val("to_err", 32'(err), 1);
        check_val("to_busy", 32'(busy), 0);
        check_val("to_ready", 32'(in_ready), 1);
        load(21, T, 1'b0, 1'b0);
        check_stream(1'b0, 1'b0);
        check_val("to_err_job", 32'(err), 1);
        finish_job();
        check_val("to_err_sticky", 32'(err), 1);
`else
        finish_job();
        check_val("err_tied", 32'(err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
